// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle controller: states, opcodes, mux codes.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a. Memory wait states are enabled by MIPS_CTRL_MEM_HANDSHAKE_EN in the users of this package.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REXEC  = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_IEXEC  = 4'd10,
    ST_IWB    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUB_REGB    = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_IMM   = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // True for every opcode the controller knows how to sequence.
  function automatic logic op_is_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: op_is_known = 1'b1;
      default:                       op_is_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational decode of (state, latched opcode) into every datapath control.
// Latency: 0 cycles, pure combinational.
// Backpressure: FETCH PC/IR loads are qualified by fetch_go (tied high unless MIPS_CTRL_MEM_HANDSHAKE_EN).
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [5:0] op_q,
  input  logic [5:0] dec_op,
  input  logic       fetch_go,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       ext_sel,
  output logic       illegal_op
);

  // Logical immediates zero-extend; arithmetic immediates sign-extend.
  logic imm_sext;
  assign imm_sext = !((op_q == OP_ANDI) || (op_q == OP_ORI));

  // Moore output table; reset forces every strobe low regardless of state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REGB;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    ext_sel       = 1'b1;
    illegal_op    = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = fetch_go;
          pc_write  = fetch_go;
          alu_src_b = ALUB_FOUR;
        end
        ST_DECODE: begin
          // Branch target precomputed here while the opcode is decoded.
          alu_src_b  = ALUB_IMM_SH2;
          illegal_op = !op_is_known(dec_op);
        end
        ST_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
        end
        ST_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        ST_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        ST_REXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        ST_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_source     = PCSRC_ALUOUT;
          pc_write_cond = 1'b1;
        end
        ST_JUMP: begin
          pc_source = PCSRC_JUMP;
          pc_write  = 1'b1;
        end
        ST_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          alu_op    = ALUOP_IMM;
          ext_sel   = imm_sext;
        end
        ST_IWB: begin
          reg_write = 1'b1;
          ext_sel   = imm_sext;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, latched opcode and next-state logic.
// Latency: lw 5, sw/R/imm 4, beq/j 3, illegal 2 cycles (no wait states).
// Backpressure: with MIPS_CTRL_MEM_HANDSHAKE_EN, FETCH/MEMRD/MEMWR hold while mem_ready=0.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       funct_is_jr,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       ext_sel,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       mem_ok;

`ifdef MIPS_CTRL_MEM_HANDSHAKE_EN
  assign mem_ok = mem_ready;
  logic unused_inputs;
  assign unused_inputs = funct_is_jr;
`else
  assign mem_ok = 1'b1;
  logic unused_inputs;
  assign unused_inputs = funct_is_jr ^ mem_ready;
`endif

  // State and latched opcode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state sequencing; opcode is captured once, in DECODE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_FETCH:  state_d = mem_ok ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW:                     state_d = ST_MEMADR;
          OP_RTYPE:                         state_d = ST_REXEC;
          OP_BEQ:                           state_d = ST_BRANCH;
          OP_J:                             state_d = ST_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = ST_IEXEC;
          default:                          state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (op_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  state_d = mem_ok ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  state_d = mem_ok ? ST_FETCH : ST_MEMWR;
      ST_REXEC:  state_d = ST_RWB;
      ST_RWB:    state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_IEXEC:  state_d = ST_IWB;
      ST_IWB:    state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  assign state = state_q;

  mips_ctrl_outdec u_outdec (
    .reset         (reset),
    .state         (state_q),
    .op_q          (op_q),
    .dec_op        (opcode),
    .fetch_go      (mem_ok),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .ext_sel       (ext_sel),
    .illegal_op    (illegal_op)
  );

endmodule
